// File: rtl/wb_arbiter_pkg.sv
// ------------------------------------------------------------------
// wb_arbiter_pkg: register-file geometry and write-port constants
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package wb_arbiter_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_NUM      = 32;
  localparam int REG_NUM_LOG2 = 5;

  localparam logic               WRITE_ENABLE = 1'b1;
  localparam logic [REG_BUS-1:0] ZERO_WORD    = '0;

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// ------------------------------------------------------------------
// wb_fifo: small synchronous FIFO holding long-latency write-back results
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// ------------------------------------------------------------------
// wb_arbiter: merges ALU and long-unit results onto the regfile write port
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int NUM_REGS   = REG_NUM,
  parameter int ADDR_W     = REG_NUM_LOG2,
  parameter int DATA_W     = REG_BUS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0] alu_wdata,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_data;
  logic               push, pop, alu_wr;

  logic               reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]  waddr_q,     waddr_d;
  logic [DATA_W-1:0]  wdata_q,     wdata_d;
  logic [NUM_REGS-1:0] busy_q,     busy_d;

  assign lu_ready  = !fifo_full;
  assign push      = lu_valid && !fifo_full;
  assign alu_wr    = alu_we && (alu_waddr != '0);
  assign pop       = !alu_wr && !fifo_empty;
  assign head_addr = fifo_head[DATA_W +: ADDR_W];
  assign head_data = fifo_head[DATA_W-1:0];

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({lu_waddr, lu_wdata}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    reg_write_d = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    if (alu_wr) begin
      reg_write_d = WRITE_ENABLE;
      waddr_d     = alu_waddr;
      wdata_d     = alu_wdata;
    end else if (pop) begin
      reg_write_d = (head_addr != '0);
      waddr_d     = head_addr;
      wdata_d     = head_data;
    end
  end

  // A new issue to the register being retired keeps it busy
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head_addr] = 1'b0;
    end
    if (sb_set && (sb_set_addr != '0)) begin
      busy_d[sb_set_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= DATA_W'(ZERO_WORD);
      busy_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign RegWrite  = reg_write_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign chk_busy1 = busy_q[chk_addr1];
  assign chk_busy2 = busy_q[chk_addr2];

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// ------------------------------------------------------------------
// tb_wb_arbiter: directed stimulus checked against a queue-based model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_waddr = '0;
  logic [31:0] alu_wdata = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_waddr = '0;
  logic [31:0] lu_wdata = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_set_addr = '0;
  logic [4:0]  chk_addr1 = '0;
  logic [4:0]  chk_addr2 = '0;
  logic        chk_busy1, chk_busy2;
  logic        RegWrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .alu_we      (alu_we),
    .alu_waddr   (alu_waddr),
    .alu_wdata   (alu_wdata),
    .lu_valid    (lu_valid),
    .lu_ready    (lu_ready),
    .lu_waddr    (lu_waddr),
    .lu_wdata    (lu_wdata),
    .sb_set      (sb_set),
    .sb_set_addr (sb_set_addr),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .RegWrite    (RegWrite),
    .waddr       (waddr),
    .wdata       (wdata)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of pending results and a busy-bit array
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          busy[32];
  logic        m_we    = 1'b0;
  logic [4:0]  m_waddr = '0;
  logic [31:0] m_wdata = '0;

  always @(posedge clk) begin
    ent_t e;
    bit   do_push;
    if (rst) begin
      q.delete();
      foreach (busy[i]) busy[i] = 1'b0;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0;
    end else begin
      do_push = lu_valid && (q.size() < DEPTH);
      if (alu_we && alu_waddr != 0) begin
        m_we = 1'b1; m_waddr = alu_waddr; m_wdata = alu_wdata;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        m_we = (e.a != 0); m_waddr = e.a; m_wdata = e.d;
        busy[e.a] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (sb_set && sb_set_addr != 0) busy[sb_set_addr] = 1'b1;
      if (do_push) q.push_back('{a: lu_waddr, d: lu_wdata});
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_regwrite", 32'(RegWrite), 32'(m_we));
      cmp("m_waddr",    32'(waddr),    32'(m_waddr));
      cmp("m_wdata",    wdata,         m_wdata);
      cmp("m_lu_ready", 32'(lu_ready), 32'(q.size() < DEPTH));
      cmp("m_busy1",    32'(chk_busy1), 32'(busy[chk_addr1]));
      cmp("m_busy2",    32'(chk_busy2), 32'(busy[chk_addr2]));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset then idle
    cyc();
    chk_en = 1'b1;
    cyc();
    rst = 1'b0;
    cmp("rst_regwrite", 32'(RegWrite), 32'd0);
    cmp("rst_lu_ready", 32'(lu_ready), 32'd1);
    cmp("rst_wdata", wdata, 32'd0);
    for (int i = 0; i < 32; i++) begin
      chk_addr1 = 5'(i);
      chk_addr2 = 5'(31 - i);
      #1;
      cmp("rst_busy", {30'd0, chk_busy1, chk_busy2}, 32'd0);
    end
    cyc();

    // 2: ALU write, then ALU write to r0
    alu_we = 1'b1; alu_waddr = 5'd5; alu_wdata = 32'h1234;
    cyc();
    cmp("alu_regwrite", 32'(RegWrite), 32'd1);
    cmp("alu_waddr", 32'(waddr), 32'd5);
    cmp("alu_wdata", wdata, 32'h1234);
    alu_waddr = 5'd0; alu_wdata = 32'h99;
    cyc();
    cmp("alu_r0_regwrite", 32'(RegWrite), 32'd0);
    cmp("alu_r0_waddr_hold", 32'(waddr), 32'd5);
    alu_we = 1'b0;

    // 3: long op to r7
    sb_set = 1'b1; sb_set_addr = 5'd7;
    cyc();
    sb_set = 1'b0; chk_addr1 = 5'd7;
    #1 cmp("r7_busy_set", 32'(chk_busy1), 32'd1);
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'hDEAD;
    cyc();
    lu_valid = 1'b0;
    cmp("r7_push_no_write", 32'(RegWrite), 32'd0);
    cmp("r7_still_busy", 32'(chk_busy1), 32'd1);
    cyc();
    cmp("r7_regwrite", 32'(RegWrite), 32'd1);
    cmp("r7_waddr", 32'(waddr), 32'd7);
    cmp("r7_wdata", wdata, 32'hDEAD);
    cmp("r7_busy_clear", 32'(chk_busy1), 32'd0);

    // 4: ALU every cycle while two long results arrive
    for (int k = 0; k < 4; k++) begin
      alu_we = 1'b1; alu_waddr = 5'(10 + k); alu_wdata = 32'(32'hA0 + k);
      lu_valid = (k < 2);
      lu_waddr = 5'(20 + k); lu_wdata = 32'(32'h2020 + k * 32'h101);
      cyc();
      if (k == 1) cmp("fifo_full_ready", 32'(lu_ready), 32'd0);
      if (k == 3) cmp("alu_wins_waddr", 32'(waddr), 32'd13);
    end
    alu_we = 1'b0; lu_valid = 1'b0;
    cyc();
    cmp("drain0_waddr", 32'(waddr), 32'd20);
    cmp("drain0_wdata", wdata, 32'h2020);
    cyc();
    cmp("drain1_waddr", 32'(waddr), 32'd21);
    cmp("drain1_wdata", wdata, 32'h2121);
    cyc();
    cmp("drain_idle", 32'(RegWrite), 32'd0);

    // 5: set-wins on r9, then an r0 entry
    chk_addr1 = 5'd9;
    sb_set = 1'b1; sb_set_addr = 5'd9;
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h9999;
    cyc();
    lu_waddr = 5'd0; lu_wdata = 32'h55;
    cyc();
    sb_set = 1'b0; lu_valid = 1'b0;
    cmp("r9_pop_write", 32'(waddr), 32'd9);
    cmp("r9_set_wins", 32'(chk_busy1), 32'd1);
    cyc();
    cmp("r0_pop_regwrite", 32'(RegWrite), 32'd0);
    cmp("r0_pop_wdata", wdata, 32'h55);

    // 6: reset with FIFO full and busy bits set
    chk_addr1 = 5'd12; chk_addr2 = 5'd13;
    alu_we = 1'b1; alu_waddr = 5'd3; alu_wdata = 32'h3;
    sb_set = 1'b1; sb_set_addr = 5'd12;
    lu_valid = 1'b1; lu_waddr = 5'd12; lu_wdata = 32'hC;
    cyc();
    sb_set_addr = 5'd13; lu_waddr = 5'd13; lu_wdata = 32'hD;
    cyc();
    sb_set = 1'b0; lu_valid = 1'b0; alu_we = 1'b0;
    cmp("full_before_rst", 32'(lu_ready), 32'd0);
    cmp("busy_before_rst", {30'd0, chk_busy1, chk_busy2}, 32'd3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cmp("rst2_regwrite", 32'(RegWrite), 32'd0);
    cmp("rst2_lu_ready", 32'(lu_ready), 32'd1);
    cmp("rst2_busy", {30'd0, chk_busy1, chk_busy2}, 32'd0);
    cyc();
    cmp("rst2_no_stale_pop", 32'(RegWrite), 32'd0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
